// File: rtl/rd_stage_bypass.sv
// rd_stage_bypass -- register-read stage between decode and execute.
//
// Accepts one decoded instruction per cycle, reads up to NUM_SRC operands
// from the register file and resolves them against NUM_BYP forwarding buses.
// Held instructions (output register OR and skid register SK) keep snooping
// the forwarding buses, so parked operands never go stale. The skid entry
// makes in_rdy a pure function of state, cutting the out_rdy -> in_rdy path.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kill held and incoming instructions
//   in_valid/in_rdy           decode handshake; in_pc, in_inst payload
//   in_src_en/in_src_addr     per-source use flag and register index (5b each)
//   rf_req_en/rf_req_addr     register-file read request
//   rf_rsp_value              register-file read data (same cycle)
//   byp_valid/addr/value      forwarding buses, lowest index has priority
//   out_valid/out_rdy         execute handshake
//   out_pc/out_inst           payload of the offered instruction
//   out_src_value             resolved operands, source i at [XLEN*i +: XLEN]
module rd_stage_bypass #(
    parameter int XLEN    = 32,
    parameter int INST_W  = 32,
    parameter int NUM_SRC = 2,
    parameter int NUM_BYP = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_rdy,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [INST_W-1:0]         in_inst,
    input  logic [NUM_SRC-1:0]        in_src_en,
    input  logic [5*NUM_SRC-1:0]      in_src_addr,
    output logic [NUM_SRC-1:0]        rf_req_en,
    output logic [5*NUM_SRC-1:0]      rf_req_addr,
    input  logic [XLEN*NUM_SRC-1:0]   rf_rsp_value,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [5*NUM_BYP-1:0]      byp_addr,
    input  logic [XLEN*NUM_BYP-1:0]   byp_value,
    output logic                      out_valid,
    input  logic                      out_rdy,
    output logic [XLEN-1:0]           out_pc,
    output logic [INST_W-1:0]         out_inst,
    output logic [XLEN*NUM_SRC-1:0]   out_src_value
);

    typedef struct packed {
        logic [XLEN-1:0]                pc;
        logic [INST_W-1:0]              inst;
        logic [NUM_SRC-1:0]             en;
        logic [NUM_SRC-1:0][4:0]        addr;
        logic [NUM_SRC-1:0][XLEN-1:0]   val;
    } entry_t;

    entry_t or_q, or_d, sk_q, sk_d;
    entry_t in_e, or_s, sk_s;
    logic   or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
    logic   acc, drn;

    // Operand resolution: x0 / unused -> 0, else lowest-index bypass hit,
    // else the supplied fallback (RF data for new, stored value for held).
    function automatic logic [XLEN-1:0] resolve(
        input logic                     en,
        input logic [4:0]               a,
        input logic [XLEN-1:0]          dflt,
        input logic [NUM_BYP-1:0]       bv,
        input logic [5*NUM_BYP-1:0]     ba,
        input logic [XLEN*NUM_BYP-1:0]  bd
    );
        logic [XLEN-1:0] r;
        r = dflt;
        // Walk from the highest index down so the lowest match wins.
        for (int j = NUM_BYP - 1; j >= 0; j--) begin
            if (bv[j] && ba[5*j +: 5] == a) r = bd[XLEN*j +: XLEN];
        end
        if (!en || a == 5'd0) r = '0;
        return r;
    endfunction

    assign in_rdy        = !sk_vld_q;
    assign acc           = in_valid && in_rdy;
    assign drn           = or_vld_q && out_rdy;
    assign rf_req_addr   = in_src_addr;
    assign rf_req_en     = in_src_en & {NUM_SRC{acc && !flush && !rst}};
    assign out_valid     = or_vld_q;
    assign out_pc        = or_q.pc;
    assign out_inst      = or_q.inst;
    assign out_src_value = or_q.val;

    always_comb begin
        in_e      = '0;
        in_e.pc   = in_pc;
        in_e.inst = in_inst;
        in_e.en   = in_src_en;
        or_s      = or_q;
        sk_s      = sk_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            in_e.addr[i] = in_src_addr[5*i +: 5];
            in_e.val[i]  = resolve(in_src_en[i], in_src_addr[5*i +: 5],
                                   rf_rsp_value[XLEN*i +: XLEN],
                                   byp_valid, byp_addr, byp_value);
            or_s.val[i]  = resolve(or_q.en[i], or_q.addr[i], or_q.val[i],
                                   byp_valid, byp_addr, byp_value);
            sk_s.val[i]  = resolve(sk_q.en[i], sk_q.addr[i], sk_q.val[i],
                                   byp_valid, byp_addr, byp_value);
        end
    end

    always_comb begin
        // Default: both entries hold and take the snooped operands.
        or_d     = or_s;
        sk_d     = sk_s;
        or_vld_d = or_vld_q;
        sk_vld_d = sk_vld_q;
        if (!or_vld_q || drn) begin
            if (sk_vld_q) begin
                or_d     = sk_s;
                or_vld_d = 1'b1;
                sk_vld_d = acc;
                if (acc) sk_d = in_e;
            end else begin
                or_vld_d = acc;
                if (acc) or_d = in_e;
            end
        end else if (acc) begin
            sk_d     = in_e;
            sk_vld_d = 1'b1;
        end
        if (flush) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_vld_q <= 1'b0;
            sk_vld_q <= 1'b0;
            or_q     <= '0;
            sk_q     <= '0;
        end else begin
            or_vld_q <= or_vld_d;
            sk_vld_q <= sk_vld_d;
            or_q     <= or_d;
            sk_q     <= sk_d;
        end
    end

endmodule

// File: doc/rd_stage_bypass.md
# rd_stage_bypass

Parametrised register-read stage that sits between decode and execute. It accepts one decoded instruction per cycle over a valid/ready handshake and reads up to NUM_SRC source operands from the register file. Operands are resolved against NUM_BYP forwarding buses, and forwarding keeps being applied while an instruction is parked in the stage, so held operands never go stale. A one-entry skid buffer breaks the combinational ready path from execute back to decode.

## Interface
Parameters:
- XLEN, 32, operand width in bits
- INST_W, 32, raw instruction width
- NUM_SRC, 2, number of source operands per instruction (1..4)
- NUM_BYP, 2, number of forwarding buses (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming instructions
- in_valid  in  1  decode offers an instruction
- in_rdy  out  1  stage accepts the offered instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_inst  in  INST_W  raw instruction
- in_src_en  in  NUM_SRC  per-source "operand used" flags
- in_src_addr  in  5*NUM_SRC  per-source register index; source i occupies bits [5i+4:5i]
- rf_req_en  out  NUM_SRC  register-file read enables
- rf_req_addr  out  5*NUM_SRC  register-file read addresses
- rf_rsp_value  in  XLEN*NUM_SRC  register-file read data; combinational, same cycle as the request
- byp_valid  in  NUM_BYP  forwarding bus j carries a write this cycle
- byp_addr  in  5*NUM_BYP  forwarding destination registers
- byp_value  in  XLEN*NUM_BYP  forwarding data
- out_valid  out  1  execute is offered an instruction
- out_rdy  in  1  execute accepts the offered instruction
- out_pc  out  XLEN  PC of the offered instruction
- out_inst  out  INST_W  raw instruction of the offered instruction
- out_src_value  out  XLEN*NUM_SRC  resolved operands

## Operation
- Storage:
  - Output register (OR) drives the out_* ports.
  - Skid register (SK) has the same fields as OR.
  - Each of OR and SK has its own valid bit, plus per-source address and enable fields.
- Read request: rf_req_en[i] = in_valid && in_rdy && in_src_en[i] && !flush && !rst. rf_req_addr = in_src_addr, passed through unconditionally.
- Operand resolution applies to incoming sources, OR sources and SK sources, per source i, in priority order:
  1. Address 0 or in_src_en[i]=0: the value is 0.
  2. Otherwise, the lowest-index j with byp_valid[j] && byp_addr[j]==addr wins.
  3. Otherwise, incoming sources take rf_rsp_value; held sources keep their stored value.
- Snooping: every cycle an entry stays valid in OR or SK, its sources are re-resolved against the bypass buses and written back.
- Handshake and movement:
  - in_rdy = !SK.valid. It depends only on state, never on out_rdy.
  - Accept = in_valid && in_rdy. Drain = out_valid && out_rdy.
  - When OR is empty, or OR drains this cycle: SK, if valid, moves to OR; otherwise the accepted instruction moves to OR.
  - When OR is valid and not draining: the accepted instruction moves to SK.
  - If SK moves to OR and an instruction is accepted in the same cycle, the accepted instruction loads SK. This cannot occur in practice, because in_rdy=0 whenever SK is valid.
- Ordering: instructions leave in acceptance order. There is no reordering and no drop.
- Flush and reset: both clear the OR and SK valid bits next cycle. The instruction offered in the same cycle is discarded, and rf_req_en is 0.

## Timing
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 instruction per cycle with out_rdy held high.
- Stall: out_rdy low for N cycles absorbs one extra instruction in SK. in_rdy falls in the cycle after SK fills and recovers in the cycle after SK empties.
- Reset values:
  - out_valid=0, in_rdy=1, rf_req_en=0.
  - out_pc, out_inst and out_src_value = 0.
  - SK cleared.
- out_* payload is stable while out_valid && !out_rdy, except out_src_value. It may change only through a bypass match on a held source.
- Bypass bus data is sampled in the same cycle as the bypass valid. Operands for an accepted instruction reflect that cycle's bypass buses.
- rst and flush dominate accept, drain and snoop in the same cycle.

## Test plan
- Reset, then stream 4 instructions with out_rdy=1, x1..x4 read from the RF as 0x11..0x44 → in-order outputs one cycle later, back-to-back, operands 0x11..0x44.
- Read of x5 while byp0 and byp1 both write x5, values 0xA and 0xB → operand 0xA. Read of x0 while byp0 writes x0=0xFF → operand 0.
- out_rdy=0 for 3 cycles with an instruction in OR reading x7, byp1 writes x7=0x1234 in stall cycle 2 → out_src_value switches to 0x1234 and survives the release.
- out_rdy=0 while 3 instructions are offered → OR and SK fill, in_rdy=0 from the next cycle, third held at decode. Release → exit order 1, 2, 3 with no bubble after the release.
- flush asserted with OR and SK full and in_valid=1 → next cycle out_valid=0 and in_rdy=1, no instruction emitted, rf_req_en=0 during the flush cycle.
- NUM_SRC=3, NUM_BYP=1 instance, source 2 disabled → rf_req_en=3'b011 and operand 2 = 0.
